// File: rtl/trilat_pkg.sv
// Shared definitions for the trilateration frame loader: word sizes,
// field codes, FSM encoding and the word-index helper.
package trilat_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned CNT_W_DEFAULT  = 16;
    localparam int unsigned NUM_WORDS      = 16;
    localparam int unsigned IDX_W          = 4;

    localparam logic [1:0] FLD_X = 2'd0;
    localparam logic [1:0] FLD_Y = 2'd1;
    localparam logic [1:0] FLD_Z = 2'd2;
    localparam logic [1:0] FLD_R = 2'd3;

    localparam logic [NUM_WORDS-1:0] MASK_FULL = 16'hFFFF;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    // Bank slot for an (anchor, field) pair; anchor is the upper half.
    function automatic logic [IDX_W-1:0] word_idx(input logic [1:0] anchor,
                                                 input logic [1:0] field);
        return {anchor, field};
    endfunction

endpackage

// File: rtl/trilat_edge_detect.sv
// Rising-edge detector for the solver done level.
// Ports: clk, rst (async active-high), level_i (sampled level),
//        rise_c (combinational: level high now, low last cycle).
module trilat_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_c
);

    logic done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= level_i;
        end
    end

    assign rise_c = level_i & ~done_q;

endmodule

// File: rtl/trilat_frame_loader.sv
// Collects the 16 operand words of one trilateration fix from a word stream,
// then transfers the frame into a held output bank feeding the solver.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_anchor/in_field/
//        in_data word stream; abort drops the partial frame; sol_done level
//        whose rising edge releases the output bank; x1..r4 held bank;
//        out_valid bank holds an unconsumed frame; frame_cnt transfers made.
module trilat_frame_loader
    import trilat_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_anchor,
    input  logic [1:0]        in_field,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    input  logic              sol_done,
    output logic [DATA_W-1:0] x1, x2, x3, x4,
    output logic [DATA_W-1:0] y1, y2, y3, y4,
    output logic [DATA_W-1:0] z1, z2, z3, z4,
    output logic [DATA_W-1:0] r1, r2, r3, r4,
    output logic              out_valid,
    output logic [CNT_W-1:0]  frame_cnt
);

    state_e                 state_q, state_d;
    logic [NUM_WORDS-1:0]   mask_q, mask_d;
    logic                   out_valid_q, out_valid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      load_q [NUM_WORDS];
    logic [DATA_W-1:0]      out_q  [NUM_WORDS];

    logic                   accept_c;
    logic                   release_c;
    logic                   transfer_c;
    logic [IDX_W-1:0]       wr_idx_c;
    logic [NUM_WORDS-1:0]   wr_bit_c;

    // Solver done rising edge
    trilat_edge_detect u_done_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (sol_done),
        .rise_c  (release_c)
    );

    assign in_ready = (state_q == ST_FILL);
    assign accept_c = in_valid && in_ready;
    assign wr_idx_c = word_idx(in_anchor, in_field);
    assign wr_bit_c = NUM_WORDS'(1) << wr_idx_c;

    // Next-state, mask, output-valid and counter logic
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        transfer_c  = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (accept_c) begin
                    mask_d = mask_q | wr_bit_c;
                    if (mask_d == MASK_FULL) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (!out_valid_q || release_c) begin
                    transfer_c = 1'b1;
                    mask_d     = '0;
                    state_d    = ST_FILL;
                end
            end
        endcase

        // Abort beats both an accepted word and a pending transfer
        if (abort) begin
            state_d    = ST_FILL;
            mask_d     = '0;
            transfer_c = 1'b0;
        end

        // A transfer on a release edge keeps out_valid high (no bubble)
        if (transfer_c) begin
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
        end else if (release_c) begin
            out_valid_d = 1'b0;
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // Load and output banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                load_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            if (accept_c && !abort) begin
                load_q[wr_idx_c] <= in_data;
            end
            if (transfer_c) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    out_q[i] <= load_q[i];
                end
            end
        end
    end

    assign x1 = out_q[word_idx(2'd0, FLD_X)];
    assign y1 = out_q[word_idx(2'd0, FLD_Y)];
    assign z1 = out_q[word_idx(2'd0, FLD_Z)];
    assign r1 = out_q[word_idx(2'd0, FLD_R)];
    assign x2 = out_q[word_idx(2'd1, FLD_X)];
    assign y2 = out_q[word_idx(2'd1, FLD_Y)];
    assign z2 = out_q[word_idx(2'd1, FLD_Z)];
    assign r2 = out_q[word_idx(2'd1, FLD_R)];
    assign x3 = out_q[word_idx(2'd2, FLD_X)];
    assign y3 = out_q[word_idx(2'd2, FLD_Y)];
    assign z3 = out_q[word_idx(2'd2, FLD_Z)];
    assign r3 = out_q[word_idx(2'd2, FLD_R)];
    assign x4 = out_q[word_idx(2'd3, FLD_X)];
    assign y4 = out_q[word_idx(2'd3, FLD_Y)];
    assign z4 = out_q[word_idx(2'd3, FLD_Z)];
    assign r4 = out_q[word_idx(2'd3, FLD_R)];

    assign out_valid = out_valid_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_trilat_frame_loader.sv
// Scoreboard bench for trilat_frame_loader: the driver pushes each complete
// frame it issues; the monitor pops and compares on every frame_cnt step.
module tb_trilat_frame_loader;

    typedef logic [15:0][63:0] frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_anchor = 2'd0;
    logic [1:0]  in_field = 2'd0;
    logic [63:0] in_data = 64'd0;
    logic        abort = 1'b0;
    logic        sol_done = 1'b0;
    logic [63:0] x1, x2, x3, x4, y1, y2, y3, y4;
    logic [63:0] z1, z2, z3, z4, r1, r2, r3, r4;
    logic        out_valid;
    logic [15:0] frame_cnt;
    frame_t      act;

    frame_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    trilat_frame_loader #(.DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_anchor(in_anchor), .in_field(in_field), .in_data(in_data),
        .abort(abort), .sol_done(sol_done),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .z1(z1), .z2(z2), .z3(z3), .z4(z4),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .out_valid(out_valid), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    assign act = {r4, z4, y4, x4, r3, z3, y3, x3, r2, z2, y2, x2, r1, z1, y1, x1};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic send_word(input int idx, input logic [63:0] d, input logic ab);
        logic ok;
        ok        = 1'b0;
        in_anchor = 2'(idx >> 2);
        in_field  = 2'(idx);
        in_data   = d;
        in_valid  = 1'b1;
        abort     = ab;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input logic rev);
        exp_q.push_back(f);
        for (int i = 0; i < 16; i++) begin
            send_word(rev ? 15 - i : i, f[rev ? 15 - i : i], 1'b0);
        end
    endtask

    // Monitor: every frame_cnt step is a transfer; compare against scoreboard
    initial begin
        logic [15:0] last;
        frame_t      e;
        last = 16'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 16'd0;
            end else if (frame_cnt != last) begin
                chk("cnt_step", 64'(frame_cnt), 64'(16'(last + 16'd1)));
                chk("xfer_valid", 64'(out_valid), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < 16; i++) begin
                        chk($sformatf("word%0d", i), act[i], e[i]);
                    end
                end
                last = frame_cnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        frame_t f;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_x1", x1, 64'd0);

        // Basic load, reverse order, value = 100*anchor + field
        for (int i = 0; i < 16; i++) f[i] = 64'(100 * (i / 4) + (i % 4));
        send_frame(f, 1'b1);
        chk("basic_ready_low", 64'(in_ready), 64'd0);
        chk("basic_not_yet", 64'(out_valid), 64'd0);
        tick();
        chk("basic_ready_back", 64'(in_ready), 64'd1);
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_cnt", 64'(frame_cnt), 64'd1);
        chk("basic_x4", x4, 64'd300);
        chk("basic_r4", r4, 64'd303);

        // Release only: no pending frame
        sol_done = 1'b1;
        tick();
        chk("rel_valid_low", 64'(out_valid), 64'd0);
        chk("rel_x4_kept", x4, 64'd300);
        chk("rel_r1_kept", r1, 64'd3);
        sol_done = 1'b0;
        tick();

        // Overwrite: x2=5 then x2=9, then the other 15 fields
        for (int i = 0; i < 16; i++) f[i] = 64'h1000 + 64'(i);
        f[4] = 64'd9;
        exp_q.push_back(f);
        send_word(4, 64'd5, 1'b0);
        send_word(4, 64'd9, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("ovw_not_full", 64'(in_ready), 64'd1);
            if (i != 4) send_word(i, f[i], 1'b0);
        end
        chk("ovw_full", 64'(in_ready), 64'd0);
        tick();
        chk("ovw_valid", 64'(out_valid), 64'd1);
        chk("ovw_cnt", 64'(frame_cnt), 64'd2);

        // Backpressure: frame B waits behind A until a done edge
        for (int i = 0; i < 16; i++) f[i] = 64'hB000 + 64'(i);
        send_frame(f, 1'b0);
        repeat (3) tick();
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_x2", x2, 64'd9);
        chk("bp_hold_cnt", 64'(frame_cnt), 64'd2);
        sol_done = 1'b1;
        tick();
        chk("bp_xfer_valid", 64'(out_valid), 64'd1);
        chk("bp_xfer_cnt", 64'(frame_cnt), 64'd3);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        repeat (3) tick();
        chk("bp_level_no_release", 64'(out_valid), 64'd1);

        // Release B
        sol_done = 1'b0;
        tick();
        sol_done = 1'b1;
        tick();
        chk("rel2_valid_low", 64'(out_valid), 64'd0);
        chk("rel2_x2_kept", x2, 64'hB004);
        sol_done = 1'b0;
        tick();

        // Abort after 10 words, 11th word presented with abort
        for (int i = 0; i < 10; i++) send_word(i, 64'hDEAD0000 + 64'(i), 1'b0);
        send_word(10, 64'hDEADBEEF, 1'b1);
        for (int i = 0; i < 16; i++) f[i] = 64'hC000 + 64'(i);
        exp_q.push_back(f);
        for (int i = 10; i < 16; i++) send_word(i, f[i], 1'b0);
        chk("abort_mask_clear", 64'(in_ready), 64'd1);
        chk("abort_no_xfer", 64'(out_valid), 64'd0);
        for (int i = 0; i < 10; i++) send_word(i, f[i], 1'b0);
        tick();
        chk("abort_next_valid", 64'(out_valid), 64'd1);
        chk("abort_next_cnt", 64'(frame_cnt), 64'd4);

        // Async reset with a held frame and 7 words loaded
        for (int i = 0; i < 7; i++) send_word(i, 64'hE000 + 64'(i), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_cnt", 64'(frame_cnt), 64'd0);
        chk("arst_x1", x1, 64'd0);
        chk("arst_r4", r4, 64'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("arst_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 16; i++) f[i] = 64'hF000 + 64'(i);
        send_frame(f, 1'b0);
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_cnt", 64'(frame_cnt), 64'd1);

        repeat (2) tick();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
